ps2_led_cmd_ctrl: RTL and testbench

Host-to-keyboard command sequencer that updates the keyboard LEDs (Caps/Num/Scroll) on request. It sends the PS/2 Set-LEDs command 0xED, then the LED argument byte, through the team's PS/2 transmitter, and checks each byte for an ACK (0xFA) from the keyboard. It shares the PS/2 receive stream with the keyboard scan-code FSM. It consumes ACK/RESEND (0xFE) responses while a command is outstanding and forwards every other received byte unchanged.

---
 rtl/ps2_led_cmd_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_ps2_led_cmd_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_led_cmd_ctrl.sv
//----------------------------------------------------------------------------
// ps2_led_cmd_ctrl
//
// Updates the keyboard LEDs. It sends the PS/2 Set-LEDs command (0xED) and
// then the LED argument byte through the PS/2 transmitter. After each byte it
// waits for the keyboard's ACK (0xFA). RESEND (0xFE) or a timeout resends
// the same byte until the shared retry budget runs out.
//
// The receive stream is shared with the scan-code FSM. ACK and RESEND bytes
// are consumed only while an ACK is awaited. Every other byte is passed
// through unchanged.
//
// Handshakes:
//   led_req/led_mask : led_req is a one-cycle request. The request is always
//                      taken. In IDLE it starts a sequence. While busy it
//                      overwrites the single pending slot (last request wins).
//   tx_start/tx_data : tx_start is issued only in a cycle where tx_idle=1.
//                      tx_data is registered and holds until the next
//                      tx_start. tx_done ends the byte.
//   rx_done_tick     : a one-cycle byte-valid strobe with no back-pressure.
//                      fwd_tick is the same strobe gated combinationally by
//                      "consumed".
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   led_req, led_mask   LED update request, mask = {caps, num, scroll}
//   tx_idle, tx_done    transmitter ready / byte finished pulse
//   tx_start, tx_data   transmitter load pulse and byte
//   rx_done_tick,
//   rx_data             received byte strobe and data
//   fwd_tick, fwd_data  unconsumed receive bytes toward the scan-code FSM
//   busy                high whenever the FSM is not in IDLE
//   cmd_done, cmd_err   one-cycle completion / abort pulses
//   state_dbg           current FSM state (debug)
//----------------------------------------------------------------------------
module ps2_led_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int TW             = 22,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       led_req,
    input  logic [2:0] led_mask,
    input  logic       tx_idle,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       fwd_tick,
    output logic [7:0] fwd_data,
    output logic       busy,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic [2:0] state_dbg
);

    localparam logic [7:0]    CMD_SET_LEDS = 8'hED;
    localparam logic [7:0]    RSP_ACK      = 8'hFA;
    localparam logic [7:0]    RSP_RESEND   = 8'hFE;
    localparam logic [TW-1:0] TIMER_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_ED,
        WAIT_ED_TX,
        WAIT_ED_ACK,
        SEND_LED,
        WAIT_LED_TX,
        WAIT_LED_ACK
    } state_t;

    state_t        state, state_next;
    logic [1:0]    retry, retry_next;
    logic [TW-1:0] timer;
    logic          pending;
    logic [2:0]    pend_mask;
    logic [2:0]    mask, mask_next;
    logic          tx_start_next;
    logic [7:0]    tx_data_next;

    logic          in_ack_wait;
    logic          in_wait;
    logic          timeout;
    logic          rx_ack;
    logic          rx_resend;
    logic          consumed;
    logic          can_retry;
    logic          do_retry;

    assign in_ack_wait = (state == WAIT_ED_ACK) || (state == WAIT_LED_ACK);
    assign in_wait     = in_ack_wait || (state == WAIT_ED_TX) || (state == WAIT_LED_TX);
    assign timeout     = in_wait && (timer == TIMER_LAST);
    assign rx_ack      = rx_done_tick && (rx_data == RSP_ACK);
    assign rx_resend   = rx_done_tick && (rx_data == RSP_RESEND);
    assign can_retry   = int'(retry) < MAX_RETRY;

    // ACK/RESEND belong to this block only while it waits for one.
    // Outside the ACK waits they may be real traffic for the scan-code FSM.
    assign consumed  = in_ack_wait && (rx_ack || rx_resend);
    assign fwd_tick  = rx_done_tick && !consumed;
    assign fwd_data  = rx_data;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Next-state, retry handling and the completion pulses. cmd_done and
    // cmd_err are issued in the cycle the FSM leaves for IDLE. A pending
    // request is therefore picked up in the cycle right after the pulse.
    always_comb begin
        state_next    = state;
        retry_next    = retry;
        mask_next     = mask;
        tx_start_next = 1'b0;
        tx_data_next  = tx_data;
        cmd_done      = 1'b0;
        cmd_err       = 1'b0;
        do_retry      = 1'b0;

        case (state)
            IDLE: begin
                if (led_req || pending) begin
                    mask_next  = led_req ? led_mask : pend_mask;
                    retry_next = 2'd0;
                    state_next = SEND_ED;
                end
            end
            SEND_ED: begin
                if (tx_idle) begin
                    tx_start_next = 1'b1;
                    tx_data_next  = CMD_SET_LEDS;
                    state_next    = WAIT_ED_TX;
                end
            end
            WAIT_ED_TX: begin
                if (tx_done)      state_next = WAIT_ED_ACK;
                else if (timeout) do_retry   = 1'b1;
            end
            WAIT_ED_ACK: begin
                // An ACK beats a timeout that expires in the same cycle.
                if (rx_ack)                      state_next = SEND_LED;
                else if (rx_resend || timeout)   do_retry   = 1'b1;
            end
            SEND_LED: begin
                if (tx_idle) begin
                    tx_start_next = 1'b1;
                    tx_data_next  = {5'b0, mask};
                    state_next    = WAIT_LED_TX;
                end
            end
            WAIT_LED_TX: begin
                if (tx_done)      state_next = WAIT_LED_ACK;
                else if (timeout) do_retry   = 1'b1;
            end
            WAIT_LED_ACK: begin
                if (rx_ack) begin
                    cmd_done   = 1'b1;
                    state_next = IDLE;
                end else if (rx_resend || timeout) begin
                    do_retry = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // One retry budget covers both bytes. A failure resends only the
        // byte that failed.
        if (do_retry) begin
            if (can_retry) begin
                retry_next = retry + 2'd1;
                state_next = ((state == WAIT_ED_TX) || (state == WAIT_ED_ACK))
                             ? SEND_ED : SEND_LED;
            end else begin
                cmd_err    = 1'b1;
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            retry    <= 2'd0;
            mask     <= 3'd0;
            tx_start <= 1'b0;
            tx_data  <= 8'd0;
        end else begin
            state    <= state_next;
            retry    <= retry_next;
            mask     <= mask_next;
            tx_start <= tx_start_next;
            tx_data  <= tx_data_next;
        end
    end

    // The timer is zero on the first cycle of every wait state. It only
    // counts while the FSM stays in the same wait state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (!in_wait || (state_next != state)) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Single-entry pending slot for requests that arrive while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= 1'b0;
            pend_mask <= 3'd0;
        end else if (led_req && (state != IDLE)) begin
            pending   <= 1'b1;
            pend_mask <= led_mask;
        end else if ((state == IDLE) && (state_next == SEND_ED)) begin
            pending   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_led_cmd_ctrl.sv
module tb_ps2_led_cmd_ctrl;

  localparam int TIMEOUT_CYCLES = 100;
  localparam int TW             = 7;
  localparam int MAX_RETRY      = 3;

  // Keyboard/transmitter reaction codes used in response scripts.
  localparam int R_ACK    = 8'hFA;
  localparam int R_RESEND = 8'hFE;
  localparam int R_SILENT = 0;   // no reply to this byte -> ack timeout
  localparam int R_STALL  = 1;   // transmitter never finishes -> tx timeout

  localparam logic [1:0] EV_DONE = 2'b01;
  localparam logic [1:0] EV_ERR  = 2'b10;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       led_req;
  logic [2:0] led_mask;
  logic       tx_idle;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       fwd_tick;
  logic [7:0] fwd_data;
  logic       busy;
  logic       cmd_done;
  logic       cmd_err;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_led_cmd_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW(TW),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .led_req(led_req),
    .led_mask(led_mask),
    .tx_idle(tx_idle),
    .tx_done(tx_done),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .rx_done_tick(rx_done_tick),
    .rx_data(rx_data),
    .fwd_tick(fwd_tick),
    .fwd_data(fwd_data),
    .busy(busy),
    .cmd_done(cmd_done),
    .cmd_err(cmd_err),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];      // expected transmitted bytes, in order
  logic [7:0] exp_fwd_q[$];  // expected forwarded receive bytes
  logic [1:0] exp_evt_q[$];  // expected completion events
  int         resp_q[$];     // keyboard reaction per transmitted byte
  logic [2:0] inj_q[$];      // led_req masks injected while busy
  int         n_checks = 0;
  int         n_errors = 0;
  int         evt_cnt  = 0;
  int         scan_pct = 30;
  logic [7:0] last_tx  = 8'h00;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: compares every DUT output event against the queues.
  always @(negedge clk) begin
    if (tx_start) begin
      if (exp_q.size() == 0) fail_now("tx_unexpected", $sformatf("got byte %02h, expected none", tx_data));
      else begin
        last_tx = exp_q.pop_front();
        chk("tx_data", int'(tx_data), int'(last_tx));
      end
    end
    if (tx_done) chk("tx_data_hold", int'(tx_data), int'(last_tx));
    if (cmd_done || cmd_err) begin
      evt_cnt++;
      if (exp_evt_q.size() == 0) fail_now("evt_unexpected", $sformatf("got done=%0b err=%0b, expected none", cmd_done, cmd_err));
      else chk("evt", int'({cmd_err, cmd_done}), int'(exp_evt_q.pop_front()));
    end
    if (fwd_tick) begin
      if (exp_fwd_q.size() == 0) fail_now("fwd_unexpected", $sformatf("got byte %02h, expected none", fwd_data));
      else chk("fwd_data", int'(fwd_data), int'(exp_fwd_q.pop_front()));
    end
  end

  // ---------------- reference model ----------------
  // Walks one command sequence byte by byte using the keyboard reactions
  // in resp_q from index 'first'. It pushes the expected traffic and result.
  task automatic model_seq(input logic [2:0] m, input int first, output int used);
    int k = first;
    int retries = 0;
    bit led_stage = 0;
    int r;
    forever begin
      exp_q.push_back(led_stage ? {5'b0, m} : 8'hED);
      r = (k < resp_q.size()) ? resp_q[k] : R_SILENT;
      k++;
      if (r == R_ACK) begin
        if (led_stage) begin
          exp_evt_q.push_back(EV_DONE);
          break;
        end
        led_stage = 1;
      end else if (retries == MAX_RETRY) begin
        exp_evt_q.push_back(EV_ERR);
        break;
      end else begin
        retries++;
      end
    end
    used = k - first;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] m);
    led_mask = m;
    led_req  = 1'b1;
    tick();
    led_req  = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] v);
    rx_data      = v;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
  endtask

  task automatic wait_tx_start(input string name);
    int n = 0;
    while (!tx_start && n < 300) begin
      tick();
      n++;
    end
    if (!tx_start) fail_now(name, "no tx_start within 300 cycles");
  endtask

  // Plays transmitter and keyboard until the DUT reports one completion.
  task automatic serve();
    int start = evt_cnt;
    int budget = 3000;
    int code;
    int t0 = 0;
    bit silent_prev = 0;
    while (evt_cnt == start && budget > 0) begin
      tick();
      budget--;
      if (tx_start) begin
        // The wait lasts TIMEOUT_CYCLES cycles. One SEND cycle follows.
        // Then the resent byte's tx_start is registered.
        if (silent_prev) chk("timeout_gap", cyc - t0, TIMEOUT_CYCLES + 1);
        silent_prev = 0;
        code = (resp_q.size() > 0) ? resp_q.pop_front() : R_SILENT;
        tx_idle = 1'b0;
        if (code == R_STALL) begin
          repeat (TIMEOUT_CYCLES + 10) tick();
          tx_idle = 1'b1;
        end else begin
          repeat ($urandom_range(2, 6)) tick();
          tx_done = 1'b1;
          tick();
          tx_done = 1'b0;
          tx_idle = 1'b1;
          t0 = cyc;
          if (inj_q.size() > 0) issue(inj_q.pop_front());
          repeat ($urandom_range(0, 8)) tick();
          if ($urandom_range(0, 99) < scan_pct) begin
            logic [7:0] sc;
            sc = 8'($urandom_range(0, 8'hEF));
            exp_fwd_q.push_back(sc);
            send_rx(sc);
          end
          if (code == R_SILENT) silent_prev = 1;
          else send_rx(8'(code));
        end
      end
    end
    if (evt_cnt == start) fail_now("serve_timeout", "no cmd_done/cmd_err within cycle budget");
  endtask

  task automatic run_seq(input logic [2:0] m);
    int used;
    model_seq(m, 0, used);
    issue(m);
    serve();
    resp_q.delete();
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int u1;
    int u2;
    logic [2:0] rm;
    reset = 1'b1; led_req = 1'b0; led_mask = 3'd0; tx_idle = 1'b1; tx_done = 1'b0;
    rx_done_tick = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cmd_done", int'(cmd_done), 0);
    chk("rst_cmd_err", int'(cmd_err), 0);
    tick();

    // Basic update: ED then 04, both ACKed, ACKs not forwarded.
    scan_pct = 0;
    resp_q = '{R_ACK, R_ACK};
    run_seq(3'b100);
    chk("busy_after_done", int'(busy), 0);

    // LED-byte resend.
    resp_q = '{R_ACK, R_RESEND, R_ACK};
    run_seq(3'b011);

    // Retry exhaustion on the command byte.
    resp_q = '{R_RESEND, R_RESEND, R_RESEND, R_RESEND};
    run_seq(3'b101);
    chk("busy_after_err", int'(busy), 0);

    // Ack timeout on every command byte.
    resp_q = '{R_SILENT, R_SILENT, R_SILENT, R_SILENT};
    run_seq(3'b001);

    // Transmitter timeout, then success.
    resp_q = '{R_STALL, R_ACK, R_SILENT, R_ACK};
    run_seq(3'b010);

    // Interleaved scan codes on every ack wait.
    scan_pct = 100;
    resp_q = '{R_ACK, R_ACK};
    run_seq(3'b111);
    scan_pct = 30;

    // ACK/RESEND outside an ack wait are ordinary traffic.
    repeat (3) tick();
    exp_fwd_q.push_back(8'hFA);
    send_rx(8'hFA);
    exp_fwd_q.push_back(8'hFE);
    send_rx(8'hFE);
    exp_fwd_q.push_back(8'h1C);
    send_rx(8'h1C);

    // Requests while busy: the last mask wins and is served afterwards.
    resp_q = '{R_ACK, R_ACK, R_ACK, R_ACK};
    model_seq(3'b001, 0, u1);
    model_seq(3'b110, u1, u2);
    inj_q = '{3'b010, 3'b110};
    issue(3'b001);
    serve();
    serve();
    resp_q.delete();

    // Randomized sequences.
    for (int i = 0; i < 10; i++) begin
      rm = 3'($urandom_range(0, 7));
      for (int j = 0; j < 8; j++) begin
        int r;
        r = $urandom_range(0, 9);
        resp_q.push_back((r < 6) ? R_ACK : (r < 9) ? R_RESEND : R_SILENT);
      end
      run_seq(rm);
      repeat ($urandom_range(0, 4)) tick();
    end

    // Reset during WAIT_LED_TX with a request pending.
    scan_pct = 0;
    exp_q.push_back(8'hED);
    exp_q.push_back(8'h05);
    issue(3'b101);
    wait_tx_start("rst_wait_ed");
    tx_idle = 1'b0;
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tx_idle = 1'b1;
    issue(3'b111);
    repeat (2) tick();
    send_rx(8'hFA);
    wait_tx_start("rst_wait_led");
    tx_idle = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx_start", int'(tx_start), 0);
    chk("mid_rst_tx_data", int'(tx_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cmd_done", int'(cmd_done), 0);
    chk("mid_rst_cmd_err", int'(cmd_err), 0);
    tick();
    reset = 1'b0;
    tx_idle = 1'b1;
    repeat (40) tick();
    chk("pending_cleared_busy", int'(busy), 0);

    // Everything expected must have been seen.
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_fwd_drained", exp_fwd_q.size(), 0);
    chk("exp_evt_drained", exp_evt_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
